// File: rtl/dbus_responder.sv
// -----------------------------------------------------------------------------
// dbus_responder
//
// Purpose:
//   Bridges a pipelined core data bus (separate address and data phases) onto a
//   simple word-wide memory port with a strobe/done handshake. Each accepted
//   address phase becomes exactly one memory access. The access completes
//   normally when the memory signals done. It completes with a two-cycle error
//   response if the access is illegal, or if the memory does not answer within
//   TIMEOUT cycles.
//
// Handshake semantics:
//   - An address phase transfers in any cycle where bus_aph_req and
//     bus_aph_ready are both high.
//   - The data phase of that transfer ends in the first later cycle with
//     bus_dph_ready high. bus_dph_err qualifies it as an error completion.
//   - A new address phase can be taken in the same cycle that a data phase
//     completes without error, so that transfers run back to back.
//   - On the memory side, mem_op stays high until a cycle with mem_rdy high.
//     mem_do is sampled in that same cycle. mem_rdy is ignored when mem_op is
//     low.
//
// Parameters:
//   TIMEOUT        maximum number of mem_op cycles without mem_rdy (1..255)
//
// Configuration macro:
//   DBUS_RESP_ALIGN_CHECK_EN  when defined, a misaligned half access or word
//                             access is rejected with the error response and
//                             no memory access. When undefined, the low
//                             address bits are only used for the lane mask.
//
// Ports:
//   clk            clock, rising edge
//   n_reset        asynchronous active-low reset
//   bus_aph_req    core requests an address phase
//   bus_aph_ready  address phase accepted this cycle
//   bus_haddr      byte address (valid with bus_aph_req)
//   bus_hsize      0 = byte, 1 = half, 2 = word, others illegal
//   bus_hwrite     1 = write
//   bus_wdata      write data, valid during the data phase
//   bus_rdata      read data, valid with bus_dph_ready
//   bus_dph_ready  data phase completes this cycle
//   bus_dph_err    data phase completes with an error
//   mem_adr        word-aligned memory address
//   mem_di         write data to memory
//   mem_do         read data from memory
//   mem_wren       byte-lane write enables
//   mem_op         memory access strobe
//   mem_rdy        memory access done
//   fsm_state      debug view of the controller state
//                  (0 IDLE, 1 ACCESS, 2 ERR1, 3 ERR2)
// -----------------------------------------------------------------------------
module dbus_responder #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        bus_aph_req,
  output logic        bus_aph_ready,
  input  logic [31:0] bus_haddr,
  input  logic [2:0]  bus_hsize,
  input  logic        bus_hwrite,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_dph_ready,
  output logic        bus_dph_err,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_do,
  output logic [3:0]  mem_wren,
  output logic        mem_op,
  input  logic        mem_rdy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR1   = 2'd2,
    ERR2   = 2'd3
  } state_t;

  // The counter holds the index of the current ACCESS cycle (0 on the
  // first one). When it reaches TIMEOUT-1 without mem_rdy, mem_op has been
  // high for exactly TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  tmo_cnt;
  logic [31:0] haddr_q;
  logic [2:0]  hsize_q;
  logic        hwrite_q;

  logic        aph_accept;
  logic        aph_illegal;
  logic        tmo_hit;
  logic [3:0]  lane_mask;

  // ---------------------------------------------------------------------------
  // Address-phase legality (decoded from the live bus inputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    aph_illegal = (bus_hsize > 3'd2);
`ifdef DBUS_RESP_ALIGN_CHECK_EN
    if ((bus_hsize == 3'd1) && bus_haddr[0]) begin
      aph_illegal = 1'b1;
    end
    if ((bus_hsize == 3'd2) && (bus_haddr[1:0] != 2'b00)) begin
      aph_illegal = 1'b1;
    end
`endif
  end

  assign aph_accept = bus_aph_req && bus_aph_ready;
  assign tmo_hit    = (state == ACCESS) && (tmo_cnt == TMO_LAST);

  // ---------------------------------------------------------------------------
  // Byte-lane mask of the registered access
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_mask = 4'b0000;
    case (hsize_q)
      3'd0:    lane_mask = 4'b0001 << haddr_q[1:0];
      3'd1:    lane_mask = haddr_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (aph_accept) begin
          state_next = aph_illegal ? ERR1 : ACCESS;
        end
      end
      ACCESS: begin
        // mem_rdy wins over a timeout that lands in the same cycle.
        if (mem_rdy) begin
          if (aph_accept) begin
            state_next = aph_illegal ? ERR1 : ACCESS;
          end else begin
            state_next = IDLE;
          end
        end else if (tmo_hit) begin
          state_next = ERR1;
        end
      end
      ERR1:    state_next = ERR2;
      ERR2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_aph_ready = 1'b0;
    bus_dph_ready = 1'b0;
    bus_dph_err   = 1'b0;
    bus_rdata     = 32'h0000_0000;
    mem_op        = 1'b0;
    mem_wren      = 4'b0000;
    mem_di        = 32'h0000_0000;
    case (state)
      IDLE: begin
        bus_aph_ready = 1'b1;
      end
      ACCESS: begin
        mem_op    = 1'b1;
        bus_rdata = mem_do;
        if (hwrite_q) begin
          mem_di   = bus_wdata;
          mem_wren = lane_mask;
        end
        if (mem_rdy) begin
          bus_dph_ready = 1'b1;
          bus_aph_ready = 1'b1;
        end
      end
      ERR1: begin
        bus_dph_err = 1'b1;
      end
      ERR2: begin
        bus_dph_err   = 1'b1;
        bus_dph_ready = 1'b1;
      end
      default: begin
        bus_aph_ready = 1'b0;
      end
    endcase
  end

  assign mem_adr   = {haddr_q[31:2], 2'b00};
  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Timeout counter and registered address-phase fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tmo_cnt <= 8'd0;
    end else if (aph_accept) begin
      tmo_cnt <= 8'd0;
    end else if (state == ACCESS) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end else begin
      tmo_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      haddr_q  <= 32'h0000_0000;
      hsize_q  <= 3'd0;
      hwrite_q <= 1'b0;
    end else if (aph_accept) begin
      haddr_q  <= bus_haddr;
      hsize_q  <= bus_hsize;
      hwrite_q <= bus_hwrite;
    end
  end

endmodule
